// File: rtl/touch_spi_reader_pkg.sv
// Shared definitions for the touch-panel ADC reader: FSM encoding,
// default ADC control bytes and the fixed serial frame geometry.
package touch_spi_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_XFER_X,
    S_XFER_Y,
    S_DONE,
    S_HOLDOFF
  } stateT;

  localparam logic [7:0] CMD_X_DEFAULT = 8'h92;
  localparam logic [7:0] CMD_Y_DEFAULT = 8'hD2;

  // Frame layout in DCLK periods (1-based): command in 1..8, data in 10..21.
  localparam logic [4:0] FRAME_BITS = 5'd24;
  localparam logic [4:0] CMD_BITS   = 5'd8;
  localparam logic [4:0] DATA_FIRST = 5'd10;
  localparam logic [4:0] DATA_BITS  = 5'd12;

endpackage

// File: rtl/touch_spi_shifter.sv
// Generic 24-period serial frame engine: generates DCLK, shifts the command
// out MSB first and shifts the 12-bit conversion result in.
module touch_spi_shifter
  import touch_spi_reader_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CMD_BITS-1:0]  cmd,
  input  logic                 sdi,
  output logic                 sclk,
  output logic                 sdo,
  output logic                 done,
  output logic [DATA_BITS-1:0] data
);

  logic                active;
  logic [7:0]          divCnt;
  logic [4:0]          bitCnt;
  logic [CMD_BITS-1:0] cmdReg;
  logic                phaseEnd;
  logic                inData;

  assign phaseEnd = active && (divCnt == 8'(CLK_DIV - 1));
  assign done     = phaseEnd && sclk && (bitCnt == FRAME_BITS - 5'd1);
  assign inData   = (bitCnt >= DATA_FIRST - 5'd1) &&
                    (bitCnt <  DATA_FIRST + DATA_BITS - 5'd1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
      divCnt <= '0;
      bitCnt <= '0;
      cmdReg <= '0;
      sclk   <= 1'b0;
      sdo    <= 1'b0;
      data   <= '0;
    end else if (start) begin
      // Accepted when idle or on the final clock of a frame, so back-to-back
      // frames follow with no extra gap.
      active <= 1'b1;
      divCnt <= '0;
      bitCnt <= '0;
      cmdReg <= cmd;
      sclk   <= 1'b0;
      sdo    <= cmd[CMD_BITS-1];
    end else if (phaseEnd) begin
      divCnt <= '0;
      if (!sclk) begin
        sclk <= 1'b1;
      end else begin
        sclk <= 1'b0;
        if (inData) data <= {data[DATA_BITS-2:0], sdi};
        if (done) begin
          active <= 1'b0;
          sdo    <= 1'b0;
        end else begin
          bitCnt <= bitCnt + 5'd1;
          sdo    <= cmdReg[CMD_BITS-2];
          cmdReg <= {cmdReg[CMD_BITS-2:0], 1'b0};
        end
      end
    end else if (active) begin
      divCnt <= divCnt + 8'd1;
    end
  end

endmodule

// File: rtl/touch_spi_reader.sv
// Touch-panel ADC front end: debounces pen-down, converts X then Y, and
// presents each valid pair with a one-cycle new_coord strobe.
module touch_spi_reader
  import touch_spi_reader_pkg::*;
#(
  parameter int         CLK_DIV    = 25,
  parameter int         DEBOUNCE   = 500000,
  parameter int         SAMPLE_GAP = 2500000,
  parameter logic [7:0] CMD_X      = CMD_X_DEFAULT,
  parameter logic [7:0] CMD_Y      = CMD_Y_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iADC_PENIRQ_n,
  input  logic        iADC_DOUT,
  output logic        oADC_DIN,
  output logic        oADC_DCLK,
  output logic        oADC_CS_n,
  output logic [11:0] x_coord,
  output logic [11:0] y_coord,
  output logic        new_coord,
  output logic        pen_down
);

  stateT       state, stateNext;
  logic [31:0] cnt, cntNext;
  logic [1:0]  penSync, doutSync;
  logic        penLow;
  logic        csN, csNNext;
  logic        startReg, startNext;
  logic [11:0] xHold, xHoldNext, xNext, yNext;
  logic        newNext, penNext;
  logic        shStart, shDone;
  logic [11:0] shData;
  logic [7:0]  shCmd;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      penSync  <= 2'b11;
      doutSync <= 2'b00;
    end else begin
      penSync  <= {penSync[0], iADC_PENIRQ_n};
      doutSync <= {doutSync[0], iADC_DOUT};
    end
  end

  assign penLow    = !penSync[1];
  assign shStart   = startReg || (state == S_XFER_X && shDone);
  assign shCmd     = startReg ? CMD_X : CMD_Y;
  assign oADC_CS_n = csN;

  touch_spi_shifter #(.CLK_DIV(CLK_DIV)) shifter (
    .clock (clock),
    .reset (reset),
    .start (shStart),
    .cmd   (shCmd),
    .sdi   (doutSync[1]),
    .sclk  (oADC_DCLK),
    .sdo   (oADC_DIN),
    .done  (shDone),
    .data  (shData)
  );

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    csNNext   = csN;
    startNext = 1'b0;
    xHoldNext = xHold;
    xNext     = x_coord;
    yNext     = y_coord;
    newNext   = 1'b0;
    penNext   = pen_down;
    case (state)
      S_IDLE: begin
        if (penLow) begin
          stateNext = S_DEBOUNCE;
          cntNext   = '0;
        end
      end
      S_DEBOUNCE: begin
        if (!penLow) begin
          stateNext = S_IDLE;
        end else if (cnt == 32'(DEBOUNCE - 1)) begin
          stateNext = S_XFER_X;
          penNext   = 1'b1;
          csNNext   = 1'b0;
          startNext = 1'b1;
        end else begin
          cntNext = cnt + 32'd1;
        end
      end
      S_XFER_X: begin
        if (shDone) begin
          xHoldNext = shData;
          stateNext = S_XFER_Y;
        end
      end
      S_XFER_Y: begin
        if (shDone) begin
          csNNext   = 1'b1;
          stateNext = S_DONE;
        end
      end
      S_DONE: begin
        // Validity of the pair is decided only here, after the full frame.
        if (penLow) begin
          xNext     = xHold;
          yNext     = shData;
          newNext   = 1'b1;
          cntNext   = '0;
          stateNext = S_HOLDOFF;
        end else begin
          penNext   = 1'b0;
          stateNext = S_IDLE;
        end
      end
      S_HOLDOFF: begin
        if (!penLow) begin
          penNext   = 1'b0;
          stateNext = S_IDLE;
        end else if (cnt == 32'(SAMPLE_GAP - 1)) begin
          stateNext = S_XFER_X;
          csNNext   = 1'b0;
          startNext = 1'b1;
        end else begin
          cntNext = cnt + 32'd1;
        end
      end
      default: stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      csN       <= 1'b1;
      startReg  <= 1'b0;
      xHold     <= '0;
      x_coord   <= '0;
      y_coord   <= '0;
      new_coord <= 1'b0;
      pen_down  <= 1'b0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      csN       <= csNNext;
      startReg  <= startNext;
      xHold     <= xHoldNext;
      x_coord   <= xNext;
      y_coord   <= yNext;
      new_coord <= newNext;
      pen_down  <= penNext;
    end
  end

endmodule

// File: tb/tb_touch_spi_reader.sv
// Directed bench for touch_spi_reader with a behavioural ADC model that
// answers each 24-period frame with the configured X/Y words.
module tb_touch_spi_reader;

  localparam int CDIV = 4;
  localparam int DEB  = 1000;
  localparam int GAP  = 5000;

  logic        clock;
  logic        resetN;
  logic        penirqN;
  logic        adcDout;
  logic        din, dclk, csN, newCoord, penDown;
  logic [11:0] xCoord, yCoord;

  touch_spi_reader #(.CLK_DIV(CDIV), .DEBOUNCE(DEB), .SAMPLE_GAP(GAP)) dut (
    .clock        (clock),
    .reset        (resetN),
    .iADC_PENIRQ_n(penirqN),
    .iADC_DOUT    (adcDout),
    .oADC_DIN     (din),
    .oADC_DCLK    (dclk),
    .oADC_CS_n    (csN),
    .x_coord      (xCoord),
    .y_coord      (yCoord),
    .new_coord    (newCoord),
    .pen_down     (penDown)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int nApplied = 0;
  int nMiss    = 0;

  // ADC model and protocol monitor, sampled on the falling clock edge.
  logic [11:0] adcX, adcY;
  int          cyc = 0, riseCnt = 0, csFallCnt = 0, strobeCnt = 0;
  int          csFallCycle = 0, lastStrobeCycle = 0, lastRiseCyc = 0;
  int          latency = 0, gapMeasured = 0;
  int          periodErr = 0, doubleStrobe = 0, csRiseErr = 0, glitch = 0;
  logic [7:0]  capX, capY;
  logic        dclkPrev = 1'b0, csPrev = 1'b1, ncPrev = 1'b0, rstPrev = 1'b0;
  logic [11:0] xPrev = '0, yPrev = '0;

  always_comb begin
    int p;
    logic [11:0] word;
    adcDout = 1'b0;
    word    = (riseCnt > 24) ? adcY : adcX;
    p       = (riseCnt > 24) ? riseCnt - 24 : riseCnt;
    if (riseCnt >= 1 && p >= 10 && p <= 21) adcDout = word[21-p];
  end

  always @(negedge clock) begin
    cyc      <= cyc + 1;
    dclkPrev <= dclk;
    csPrev   <= csN;
    ncPrev   <= newCoord;
    rstPrev  <= resetN;
    xPrev    <= xCoord;
    yPrev    <= yCoord;
    if (!csN && csPrev) begin
      csFallCnt   <= csFallCnt + 1;
      csFallCycle <= cyc;
      gapMeasured <= cyc - lastStrobeCycle;
      riseCnt     <= 0;
      capX        <= '0;
      capY        <= '0;
    end else if (dclk && !dclkPrev) begin
      riseCnt     <= riseCnt + 1;
      lastRiseCyc <= cyc;
      if (riseCnt != 0 && (cyc - lastRiseCyc) != 2 * CDIV) periodErr <= periodErr + 1;
      if (riseCnt < 8) capX <= {capX[6:0], din};
      else if (riseCnt >= 24 && riseCnt < 32) capY <= {capY[6:0], din};
    end
    if (csN && !csPrev && dclk) csRiseErr <= csRiseErr + 1;
    if (newCoord) begin
      strobeCnt       <= strobeCnt + 1;
      lastStrobeCycle <= cyc;
      latency         <= cyc - csFallCycle;
      if (ncPrev) doubleStrobe <= doubleStrobe + 1;
    end
    if (resetN && rstPrev && !newCoord && (xCoord != xPrev || yCoord != yPrev))
      glitch <= glitch + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int probe(input int which);
    case (which)
      0:       return csFallCnt;
      1:       return strobeCnt;
      2:       return riseCnt;
      default: return int'(csN);
    endcase
  endfunction

  task automatic waitFor(input string name, input int which, input int target, input int maxCyc);
    int n;
    n = 0;
    while (probe(which) < target && n < maxCyc) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk({name, "_timeout"}, 32'(probe(which) < target), 32'd0);
  endtask

  typedef struct {
    logic [11:0] adcX;
    logic [11:0] adcY;
    bit          penUpInY;
    bit          checkGap;
    logic [11:0] expX;
    logic [11:0] expY;
  } vecT;

  vecT vecs[4];

  initial begin
    int startStrobe, startFall, penHigh, relCyc, dt;

    vecs[0] = '{12'hFFF, 12'h000, 1'b0, 1'b0, 12'hFFF, 12'h000};
    vecs[1] = '{12'h010, 12'h31C, 1'b0, 1'b1, 12'h010, 12'h31C};
    vecs[2] = '{12'h7A5, 12'h31C, 1'b0, 1'b1, 12'h7A5, 12'h31C};
    vecs[3] = '{12'h5A5, 12'h0F0, 1'b1, 1'b1, 12'h7A5, 12'h31C};

    resetN  = 1'b0;
    penirqN = 1'b1;
    adcX    = '0;
    adcY    = '0;
    repeat (5) @(posedge clock);
    #1;
    chk("reset_cs_n", 32'(csN), 32'd1);
    chk("reset_dclk", 32'(dclk), 32'd0);
    chk("reset_din", 32'(din), 32'd0);
    chk("reset_x", 32'(xCoord), 32'd0);
    chk("reset_y", 32'(yCoord), 32'd0);
    chk("reset_new_coord", 32'(newCoord), 32'd0);
    chk("reset_pen_down", 32'(penDown), 32'd0);
    @(negedge clock);
    resetN = 1'b1;

    // Short press below the debounce time must be ignored entirely.
    penHigh = 0;
    for (int i = 0; i < 2600; i++) begin
      @(posedge clock);
      if (i == 600) penirqN = 1'b1;
      else if (i == 0) penirqN = 1'b0;
      #1;
      if (penDown) penHigh++;
    end
    chk("short_press_cs_falls", 32'(csFallCnt), 32'd0);
    chk("short_press_strobes", 32'(strobeCnt), 32'd0);
    chk("short_press_pen_down_cycles", 32'(penHigh), 32'd0);
    $display("short press: cs falls=%0d strobes=%0d", csFallCnt, strobeCnt);

    penirqN = 1'b0;
    for (int i = 0; i < 4; i++) begin
      adcX        = vecs[i].adcX;
      adcY        = vecs[i].adcY;
      startStrobe = strobeCnt;
      startFall   = csFallCnt;
      waitFor($sformatf("v%0d_cs_fall", i), 0, startFall + 1, DEB + GAP + 200);
      if (vecs[i].checkGap) chk($sformatf("v%0d_gap", i), 32'(gapMeasured), 32'(GAP));
      if (vecs[i].penUpInY) begin
        waitFor($sformatf("v%0d_rise30", i), 2, 30, 400);
        penirqN = 1'b1;
        waitFor($sformatf("v%0d_cs_high", i), 3, 1, 400);
        repeat (10) @(posedge clock);
        #1;
        chk($sformatf("v%0d_no_strobe", i), 32'(strobeCnt - startStrobe), 32'd0);
        chk($sformatf("v%0d_rises", i), 32'(riseCnt), 32'd48);
        chk($sformatf("v%0d_pen_down", i), 32'(penDown), 32'd0);
      end else begin
        waitFor($sformatf("v%0d_strobe", i), 1, startStrobe + 1, 1000);
        chk($sformatf("v%0d_latency", i), 32'(latency), 32'(96 * CDIV + 2));
        chk($sformatf("v%0d_cmd_x", i), 32'(capX), 32'h92);
        chk($sformatf("v%0d_cmd_y", i), 32'(capY), 32'hD2);
        chk($sformatf("v%0d_rises", i), 32'(riseCnt), 32'd48);
        chk($sformatf("v%0d_pen_down", i), 32'(penDown), 32'd1);
      end
      chk($sformatf("v%0d_x", i), 32'(xCoord), 32'(vecs[i].expX));
      chk($sformatf("v%0d_y", i), 32'(yCoord), 32'(vecs[i].expY));
      $display("vector %0d: adc=%03h/%03h x=%03h y=%03h pen_down=%0d latency=%0d",
               i, vecs[i].adcX, vecs[i].adcY, xCoord, yCoord, penDown, latency);
    end

    // Reset in the middle of an X frame, then a fresh debounce with pen held.
    adcX      = 12'h7A5;
    adcY      = 12'h31C;
    repeat (20) @(posedge clock);
    penirqN   = 1'b0;
    startFall = csFallCnt;
    waitFor("rst_cs_fall", 0, startFall + 1, DEB + 200);
    waitFor("rst_rise15", 2, 15, 200);
    resetN = 1'b0;
    #1;
    chk("rst_mid_cs_n", 32'(csN), 32'd1);
    chk("rst_mid_dclk", 32'(dclk), 32'd0);
    chk("rst_mid_x", 32'(xCoord), 32'd0);
    chk("rst_mid_y", 32'(yCoord), 32'd0);
    chk("rst_mid_pen_down", 32'(penDown), 32'd0);
    repeat (5) @(posedge clock);
    @(negedge clock);
    resetN      = 1'b1;
    relCyc      = cyc;
    startFall   = csFallCnt;
    startStrobe = strobeCnt;
    waitFor("rst_refall", 0, startFall + 1, DEB + 200);
    dt = csFallCycle - relCyc;
    chk("rst_redebounce", 32'(dt >= DEB && dt <= DEB + 10), 32'd1);
    waitFor("rst_strobe", 1, startStrobe + 1, 1000);
    chk("rst_frame_x", 32'(xCoord), 32'h7A5);
    chk("rst_frame_y", 32'(yCoord), 32'h31C);
    $display("reset recovery: cs fall %0d cycles after release, x=%03h y=%03h", dt, xCoord, yCoord);
    penirqN = 1'b1;
    repeat (20) @(posedge clock);
    #1;

    chk("dclk_period_errors", 32'(periodErr), 32'd0);
    chk("double_strobes", 32'(doubleStrobe), 32'd0);
    chk("dclk_high_at_cs_rise", 32'(csRiseErr), 32'd0);
    chk("coord_glitches", 32'(glitch), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
    $finish;
  end

endmodule
